// File: rtl/axis_pkg.sv
// ============================================================================
// axis_pkg : shared helpers for AXI Stream muxes, demuxes and arbiters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

  // Index width that stays at least 1 bit, so single-source blocks still get a legal port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_if.sv
// ============================================================================
// axis_if : minimal AXI Stream bundle (tvalid / tdata / tready)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tready;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin pick; rotate, priority encode, un-rotate
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
  import axis_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  always_comb begin
    logic [N-1:0] rot;
    logic         found;
    int           src;
    int           off;
    int           w;
    rot   = '0;
    found = 1'b0;
    off   = 0;
    // ptr is always below N, so a single subtraction implements the modulo.
    for (int j = 0; j < N; j++) begin
      src = j + int'(ptr);
      if (src >= N) src = src - N;
      rot[j] = req[src];
    end
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = j;
      end
    end
    w = off + int'(ptr);
    if (w >= N) w = w - N;
    win = IDX_W'(w);
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// axis_rr_arbiter : round-robin N:1 AXI Stream arbiter with one registered
//                   output stage and a source-index tag
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  axis_if.s                     axis_sif [N_REQ],
  axis_if.m                     axis_mif,
  output logic      [IDX_W-1:0] m_tid
);

  localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;

  if (TDATA_WIDTH <= 0) begin : g_bad_width
    $error("axis_rr_arbiter: TDATA_WIDTH must be greater than 0");
  end
  if (N_REQ < 1) begin : g_bad_nreq
    $error("axis_rr_arbiter: N_REQ must be at least 1");
  end

  logic [N_REQ-1:0]       req;
  logic [TDATA_WIDTH-1:0] req_data [N_REQ];
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   any;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       ptr;
  logic                   out_valid;
  logic [TDATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]       out_tid;
  logic                   space;
  logic                   take;

  assign space = !out_valid || axis_mif.tready;
  assign take  = rst_n && !flush && space && any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    if ($bits(axis_sif[i].tdata) != TDATA_WIDTH) begin : g_bad_req_width
      $error("axis_rr_arbiter: requester TDATA_WIDTH differs from manager");
    end
    assign req[i]             = axis_sif[i].tvalid;
    assign req_data[i]        = axis_sif[i].tdata;
    assign axis_sif[i].tready = take && (win == IDX_W'(i));
  end

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) sel_data = req_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tid   <= '0;
      ptr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (any && space) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_tid   <= win;
      ptr       <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
    end else if (axis_mif.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign axis_mif.tvalid = out_valid;
  assign axis_mif.tdata  = out_data;
  assign m_tid           = out_tid;

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
// tb_axis_rr_arbiter : directed + random bench for axis_rr_arbiter (N_REQ=3)
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       sink;
  logic [2:0] tv;
  logic [7:0] td [N];
  logic [2:0] rdy;
  logic [1:0] tid;

  axis_if #(.TDATA_WIDTH(8)) sif [N] ();
  axis_if #(.TDATA_WIDTH(8)) mif ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign sif[g].tvalid = tv[g];
    assign sif[g].tdata  = td[g];
    assign rdy[g]        = sif[g].tready;
  end
  assign mif.tready = sink;

  axis_rr_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .axis_sif (sif),
    .axis_mif (mif),
    .m_tid    (tid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one output slot plus a "next in line" pointer.
  logic       mv = 1'b0;
  logic [7:0] md = '0;
  int         mt = 0;
  int         mptr = 0;

  function automatic int mwin();
    for (int k = 0; k < N; k++) begin
      if (tv[(mptr + k) % N]) return (mptr + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      mv = 1'b0; md = '0; mt = 0; mptr = 0;
    end else if (flush) begin
      mv = 1'b0; mptr = 0;
    end else begin
      w = mwin();
      if ((|tv) && (!mv || sink)) begin
        mv = 1'b1; md = td[w]; mt = w; mptr = (w + 1) % N;
      end else if (sink) begin
        mv = 1'b0;
      end
    end
  end

  // Scoreboard: accepted beats in global order, plus per-source wait counts.
  logic       sb_on = 1'b0;
  logic [9:0] sbq [$];
  int         waits [N];
  logic [2:0] acc = '0;

  always @(negedge clk) begin
    int         w;
    logic [2:0] er;
    logic [9:0] front;
    logic       granted;
    w = mwin();
    for (int i = 0; i < N; i++)
      er[i] = rst_n && !flush && (!mv || sink) && (|tv) && (i == w);
    chk("cmp_ready", {29'd0, rdy}, {29'd0, er});
    chk("cmp_tvalid", {31'd0, mif.tvalid}, {31'd0, mv});
    if (mv) begin
      chk("cmp_tdata", {24'd0, mif.tdata}, {24'd0, md});
      chk("cmp_tid", {30'd0, tid}, 32'(mt));
    end
    chk("cmp_onehot", {31'd0, $countones(rdy) <= 1}, 32'd1);

    acc     = tv & rdy;
    granted = |acc;
    if (sb_on) begin
      if (mif.tvalid && sink) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_beat", {30'd0, tid}, 32'hFFFF);
        end else begin
          front = sbq.pop_front();
          chk("sb_order", {22'd0, tid, mif.tdata}, {22'd0, front});
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          sbq.push_back({2'(i), td[i]});
          chk("fair_wait", {31'd0, waits[i] < N}, 32'd1);
          waits[i] = 0;
        end else if (tv[i] && granted) begin
          waits[i]++;
        end else if (!tv[i]) begin
          waits[i] = 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; sink = 1'b1; tv = 3'b111;
    for (int i = 0; i < N; i++) td[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < N; i++) waits[i] = 0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_tvalid", {31'd0, mif.tvalid}, 32'd0);
    chk("rst_ready", {29'd0, rdy}, 32'd0);
    chk("rst_tid", {30'd0, tid}, 32'd0);
    chk("rst_tdata", {24'd0, mif.tdata}, 32'd0);

    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", {29'd0, rdy}, 32'b001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_valid", {31'd0, mif.tvalid}, 32'd1);
      chk("rr_tid", {30'd0, tid}, 32'(k % 3));
      chk("rr_data", {24'd0, mif.tdata}, 32'hA0 + 32'(k % 3));
    end

    // Only requester 2 active, then requester 0 joins after the pointer wraps.
    step(); flush = 1'b1; tv = 3'b000;
    step(); flush = 1'b0; tv = 3'b100; td[2] = 8'hC0;
    @(negedge clk);
    chk("only2_ready", {29'd0, rdy}, 32'b100);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) tv[0] = 1'b1;
      @(negedge clk);
      chk("only2_tid", {30'd0, tid}, 32'd2);
      chk("only2_data", {24'd0, mif.tdata}, 32'hC0);
    end
    chk("wrap_grant", {29'd0, rdy}, 32'b001);

    // Downstream stall for 4 cycles.
    step(); sink = 1'b0; tv[0] = 1'b0;
    @(negedge clk);
    chk("wrap_tid", {30'd0, tid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("stall_tid", {30'd0, tid}, 32'd0);
      chk("stall_data", {24'd0, mif.tdata}, 32'hA0);
      chk("stall_ready", {29'd0, rdy}, 32'd0);
    end
    step(); sink = 1'b1;
    @(negedge clk);
    chk("release_ready", {29'd0, rdy}, 32'b100);
    step();
    @(negedge clk);
    chk("release_tid", {30'd0, tid}, 32'd2);
    chk("release_data", {24'd0, mif.tdata}, 32'hC0);

    // Flush with a held beat and requesters 1 and 2 pending.
    step(); tv = 3'b110; td[1] = 8'hA1; sink = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", {29'd0, rdy}, 32'd0);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_tvalid", {31'd0, mif.tvalid}, 32'd0);
    chk("flush_next_grant", {29'd0, rdy}, 32'b010);
    step();
    @(negedge clk);
    chk("flush_tid", {30'd0, tid}, 32'd1);
    chk("flush_data", {24'd0, mif.tdata}, 32'hA1);

    step(); sink = 1'b1; tv = 3'b000;
    repeat (3) step();
    sb_on = 1'b1;

    // Random traffic; a valid beat holds its data until accepted.
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!tv[i] || acc[i]) begin
          tv[i] = 1'($urandom_range(0, 1));
          td[i] = 8'($urandom);
        end
      end
      sink = ($urandom_range(0, 3) != 0);
    end
    step(); tv = 3'b000; sink = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sb_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one AXI Stream manager port among `N_REQ` AXI Stream requesters. It accepts at most one beat per cycle, registers it into a single output stage, and tags it with the index of the source requester. It sits wherever several pipeline producers feed one shared consumer, for example several fetch/LSU request sources competing for one memory request channel. Downstream of it, the existing skid buffer may be placed as needed.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; must be ≥ 1.
- `IDX_W`, default `(N_REQ > 1) ? $clog2(N_REQ) : 1`: width of the source index. Derived; must not be overridden.
- `TDATA_WIDTH`: not a parameter. It is taken from `axis_mif.TDATA_WIDTH`. An elaboration-time assertion requires every `axis_sif[i].TDATA_WIDTH` to equal it, and requires it to be greater than 0.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `axis_sif[N_REQ]`  axis_if.s  array: requester streams (`tvalid`, `tdata`, `tready`).
- `axis_mif`  axis_if.m: arbitrated output stream.
- `m_tid`  out  `IDX_W`: index of the requester that produced the current `axis_mif` beat. Valid only while `axis_mif.tvalid` is 1.
- `flush`  in  1: synchronous discard of the output stage and reset of the arbitration pointer.

## Operation
Registers:
- `out_valid`, `out_data`, `out_tid`: drive `axis_mif.tvalid`, `axis_mif.tdata` and `m_tid` directly from flops.
- `ptr` (`IDX_W` bits): the highest-priority requester for the next grant.

Arbitration (combinational):
- `win` is the first `i` in the order `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1` with `axis_sif[i].tvalid` = 1.
- `any` = OR of all `tvalid`.

Definitions:
- `space` = `!out_valid || axis_mif.tready`.

Ready rule:
- `axis_sif[i].tready` = `rst_n && !flush && space && any && (i == win)`.
- At most one `tready` is high in any cycle.
- `tready` may depend on `tvalid`, which AXI Stream permits. No requester's `tvalid` depends on its own `tready`.

On an input handshake (`any && space && !flush`):
- Load `out_data` ← `axis_sif[win].tdata`, `out_tid` ← `win`, `out_valid` ← 1.
- Set `ptr` ← `win+1`, wrapping from `N_REQ-1` to 0. The wrap must be correct for non-power-of-2 `N_REQ`.

Other cases:
- Output handshake with no new input: `out_valid` ← 0.
- Downstream stall (`out_valid && !axis_mif.tready`): all output registers hold, and every `tready` is 0.
- `flush`: `out_valid` ← 0 and `ptr` ← 0. No input is accepted that cycle. Flush wins over both input and output handshakes. A beat presented downstream in a flush cycle counts as consumed only if `tready` was high.

Fairness:
- A requester that holds `tvalid` continuously is granted within `N_REQ` input handshakes.

Degenerate case:
- With `N_REQ` = 1, the block behaves as a single-register pipeline stage with `m_tid` = 0.

## Timing
- Reset values: `axis_mif.tvalid`=0, `axis_mif.tdata`=0, `m_tid`=0, `ptr`=0, all `axis_sif[i].tready`=0 while `rst_n`=0.
- Latency: input handshake in cycle t makes the beat visible on `axis_mif` in cycle t+1.
- Throughput: 1 beat per cycle while `axis_mif.tready` stays high. There are no bubbles between grants from different requesters.
- Output `tvalid`, `tdata` and `m_tid` stay stable from assertion until the output handshake, except when `flush` or reset clears them.
- Reset asserted mid-transfer: the held beat is dropped. No input is accepted during reset.

## Structure
- Shared package `axis_pkg`: an `idx_w(n)` function returning `(n>1)?$clog2(n):1`, for reuse by other stream muxes and demuxes.
- Sub-module `rr_picker`: purely combinational.
  - Parameters: `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `any`, `win`.
  - Implemented as a rotate, then priority encode, then un-rotate. It is reused by future arbiters.
- Top module: output register, pointer update and the `tready` fan-out.

## Test plan
- Reset with all requesters valid: every `tready` is 0 and `axis_mif.tvalid` is 0 during reset. First cycle after reset, with `N_REQ`=3: requester 0 is granted, and the beat appears the next cycle with `m_tid`=0.
- `N_REQ`=3, all requesters continuously valid with data `0xA0+i`, sink always ready: the output sequence is `m_tid` 0,1,2,0,1,2 with matching data and one beat per cycle.
- Only requester 2 valid for 5 cycles, sink ready: 5 consecutive beats, all with `m_tid`=2. Then requester 0 becomes valid and is granted next, because `ptr` wrapped to 0.
- Sink holds `tready`=0 for 4 cycles while a beat is held: output data and `m_tid` are unchanged, and all requester `tready` are 0. On release, throughput resumes with no duplicated or lost beat.
- `flush` pulsed while `out_valid`=1 and requesters 1 and 2 are valid: the next cycle `axis_mif.tvalid`=0 and no input was accepted. The following grant goes to requester 1, since `ptr`=0 and requester 0 is idle.
- Random `tvalid` and `tready` over 10k cycles against a scoreboard: every accepted beat appears exactly once and in order per source. No requester waits more than `N_REQ` grants while valid.
